step_rate_meter: RTL

Front-end stage of the activity tracker: conditions the raw step-sensor pulse, counts steps per second, and maintains a sliding 60-second window whose sum is the pulses-per-minute figure (`ppm`) consumed by the high-activity tracker. It also generates the 1 Hz `sec_tick` strobe that paces that downstream stage. All logic is in the system clock domain.

---
 rtl/step_rate_meter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/step_rate_meter.sv
`default_nettype none
// ============================================================================
//  Module      : step_rate_meter
//  Description : Conditions the raw step pulse, counts steps per second and
//                keeps a sliding window of per-second bins whose sum is the
//                pulses-per-minute figure. Also produces the 1 Hz sec_tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module step_rate_meter #(
    parameter int CLK_HZ = 100_000_000,
    parameter int WINDOW = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pulse_in,
    output logic       sec_tick,
    output logic [9:0] ppm,
    output logic       ppm_valid,
    output logic       window_full
);

    localparam int c_pre_w   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int c_ptr_w   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int c_sum_raw = $clog2(WINDOW * 255 + 1);
    // Never narrower than the 10-bit output so the clamp compare is exact.
    localparam int c_sum_w   = (c_sum_raw < 10) ? 10 : c_sum_raw;

    localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(CLK_HZ - 1);
    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(WINDOW - 1);
    localparam logic [c_sum_w-1:0] c_ppm_max  = c_sum_w'(1023);
    localparam logic [7:0]         c_cnt_max  = 8'hFF;

    logic               r_sync1;
    logic               r_sync2;
    logic               r_sync3;
    logic               w_edge;
    logic [c_pre_w-1:0] r_pre_cnt;
    logic               w_tick;
    logic [7:0]         r_cur_cnt;
    logic [7:0]         r_bin [WINDOW];
    logic [WINDOW-1:0]  r_valid;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] w_ptr_next;
    logic [c_sum_w-1:0] r_sum;
    logic [7:0]         w_old;
    logic [c_sum_w-1:0] w_sum_next;

    // One step is one synchronized 0->1 transition.
    assign w_edge   = r_sync2 & ~r_sync3;
    assign w_tick   = (r_pre_cnt == c_pre_last);
    assign sec_tick = w_tick;

    // Bins never written since reset contribute nothing to the window sum.
    assign w_old      = r_valid[r_wr_ptr] ? r_bin[r_wr_ptr] : 8'd0;
    assign w_sum_next = r_sum - c_sum_w'(w_old) + c_sum_w'(r_cur_cnt);
    assign w_ptr_next = (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + 1'b1;

    // Two-flop synchronizer plus the edge-detect history flop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= pulse_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // Free-running one-second prescaler; tick is the last count of the second.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pre_cnt <= '0;
        end else if (w_tick) begin
            r_pre_cnt <= '0;
        end else begin
            r_pre_cnt <= r_pre_cnt + 1'b1;
        end
    end

    // Current-second counter; an edge coincident with the tick opens the new second.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cur_cnt <= 8'd0;
        end else if (w_tick) begin
            r_cur_cnt <= w_edge ? 8'd1 : 8'd0;
        end else if (w_edge && (r_cur_cnt != c_cnt_max)) begin
            r_cur_cnt <= r_cur_cnt + 8'd1;
        end
    end

    // Bin storage is left unreset so it can map onto a RAM; validity gates reads.
    always_ff @(posedge clk) begin
        if (w_tick) begin
            r_bin[r_wr_ptr] <= r_cur_cnt;
        end
    end

    // Window bookkeeping: running sum, bin validity, write pointer and outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sum       <= '0;
            r_valid     <= '0;
            r_wr_ptr    <= '0;
            ppm         <= 10'd0;
            ppm_valid   <= 1'b0;
            window_full <= 1'b0;
        end else begin
            ppm_valid <= w_tick;
            if (w_tick) begin
                r_sum             <= w_sum_next;
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= w_ptr_next;
                ppm               <= (w_sum_next > c_ppm_max) ? 10'd1023 : w_sum_next[9:0];
                if (r_wr_ptr == c_ptr_last) begin
                    window_full <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire
